prod_accumulator: RTL
=====================

Name: prod_accumulator

Overview:
- Downstream stage of the 4x4 array multiplier.
- Consumes a stream of 8-bit products over a valid/ready handshake and sums a fixed number of terms (N_TERMS) into an accumulator.
- Presents the finished sum on a second valid/ready handshake.
- Turns the combinational multiplier into a registered multiply-accumulate (dot-product) datapath.

Parameters:
- PROD_W, 8: product input width; matches multiplier output.
- ACC_W, 12: accumulator and result width; must be >= PROD_W.
- N_TERMS, 4: products summed per result; range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- clear  input  1  synchronous abort/zero.
- prod_in  input  PROD_W  product from multiplier.
- prod_valid  input  1  prod_in valid.
- prod_ready  output  1  block accepts prod_in this cycle.
- res_data  output  ACC_W  accumulator value; a final sum when res_valid=1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes result.
- term_cnt  output  8  products accepted in the current sum.
- ovf  output  1  sticky: sum exceeded ACC_W bits.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset (async, immediate, including mid-operation):
  - state=IDLE; acc=0; term_cnt=0; ovf=0; res_valid=0.
  - prod_ready forced 0 while rst=1.
- States:
  - IDLE: acc=0, prod_ready=1.
  - ACCUM: prod_ready=1.
  - HOLD: prod_ready=0, res_valid=1.
- Accept: prod_valid && prod_ready at a rising edge. On accept, acc <= acc + zero-extended prod_in and term_cnt <= term_cnt+1.
- Transitions:
  - IDLE -> ACCUM on accept when N_TERMS>1.
  - IDLE -> HOLD on accept when N_TERMS==1.
  - ACCUM -> HOLD on the accept that makes term_cnt==N_TERMS.
  - HOLD -> IDLE on res_valid && res_ready; acc, term_cnt and ovf cleared at that edge.
- No-accept cycles (prod_valid=0): state, acc and term_cnt hold. Gaps are allowed anywhere.
- Latency: res_valid rises the cycle after the edge that accepted the final product. res_data equals the final sum in that same cycle.
- Throughput: one product per cycle; the HOLD cycle costs at least 1 bubble per result.
- HOLD: res_data, term_cnt and ovf are stable. prod_valid is ignored, and prod_in is not sampled.
- prod_ready and res_valid are decoded from registered state only. Exceptions: prod_ready is combinationally gated low by rst or clear. There is no combinational path from prod_valid or res_ready to any output.
- clear=1 at an edge, from any state: go to IDLE, acc=0, term_cnt=0, ovf=0.
  - prod_ready=0 during the clear cycle, so a product presented that cycle is not accepted.
  - clear has priority over both handshakes; a pending result is discarded.
- Arithmetic: the sum is computed at ACC_W+1 bits.
  - If the carry bit is 1: ovf <= 1 (sticky until HOLD exit, clear or rst), and acc <= low ACC_W bits (wrap).
- res_data mirrors the acc register in every state; it reads 0 in IDLE.

Optional Feature:
- Macro: PROD_ACC_SAT_EN.
- Defined: on overflow, acc saturates to 2^ACC_W-1 and stays there for the remaining terms. ovf is still set.
- Undefined: modulo-2^ACC_W wrap as above.
- All other behaviour is identical.

Test Plan:
- Reset: assert rst mid-ACCUM with acc=50 -> res_data=0, term_cnt=0, res_valid=0, ovf=0 and prod_ready=0 immediately. After release, prod_ready=1.
- Default params: back-to-back products 3,10,225,0 with res_ready=0 -> res_valid=1 one cycle after 4th accept, res_data=238, term_cnt=4, prod_ready=0.
- Backpressure: in HOLD, keep res_ready=0 for 5 cycles with prod_valid=1, prod_in=99 -> res_data stays 238, no accept. Then res_ready=1 for one cycle -> next cycle IDLE, res_data=0, prod_ready=1.
- Gapped input: products 15,15,15,15 with prod_valid low 2 cycles between each -> res_data=60, term_cnt steps 1,2,3,4 only on accept edges.
- clear: after accepting 100,200, assert clear for one cycle with prod_valid=1, prod_in=7 -> acc=0, term_cnt=0, 7 not accepted. Next sequence 1,2,3,4 -> res_data=10.
- Overflow, ACC_W=9: four products of 225 -> without macro res_data=388, ovf=1. With PROD_ACC_SAT_EN, res_data=511, ovf=1. ovf=0 after the result handshake.

Source files
------------

// File: rtl/prod_accumulator_if.sv
// Product-in / result-out handshake bundle for prod_accumulator.
// master = upstream multiplier plus result consumer; slave = the accumulator.
interface prod_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 12
);
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output prod_in, prod_valid, res_ready,
    input  prod_ready, res_data, res_valid
  );

  modport slave (
    input  prod_in, prod_valid, res_ready,
    output prod_ready, res_data, res_valid
  );
endinterface

// File: rtl/prod_accumulator.sv
// Multiply-accumulate back end: sums N_TERMS products, then holds the sum until taken.
// Define PROD_ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module prod_accumulator #(
  parameter int PROD_W  = 8,
  parameter int ACC_W   = 12,
  parameter int N_TERMS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  prod_accumulator_if.slave   bus,
  output logic [7:0]          term_cnt,
  output logic                ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W:0]    sum;
  logic [7:0]        cnt_nxt;
  logic              accept;

  // Handshake outputs come from the state register; rst/clear only ever pull ready low.
  assign bus.prod_ready = !rst && !clear && (state != HOLD);
  assign bus.res_valid  = (state == HOLD);
  assign bus.res_data   = acc;

  assign accept  = bus.prod_valid && bus.prod_ready;
  assign sum     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_in};
  assign cnt_nxt = term_cnt + 8'd1;

`ifdef PROD_ACC_SAT_EN
  assign acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      term_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      acc      <= '0;
      term_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc      <= acc_nxt;
            term_cnt <= cnt_nxt;
            if (sum[ACC_W]) ovf <= 1'b1;
            state    <= (cnt_nxt == 8'(N_TERMS)) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          // Result taken: start the next sum from zero with a fresh overflow flag.
          if (bus.res_ready) begin
            state    <= IDLE;
            acc      <= '0;
            term_cnt <= '0;
            ovf      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
